// File: rtl/cnn_pkg.sv
// Shared constants for the systolic MAC datapath and a helper that extracts one lane of a packed row.
package cnn_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int ARRAY_SIZE = 9;
  localparam int MAC_SIZE   = DATA_SIZE * ARRAY_SIZE;

  typedef logic [DATA_SIZE-1:0] lane_t;

  function automatic lane_t lane_slice(input logic [MAC_SIZE-1:0] row, input int j);
    return row[DATA_SIZE*j +: DATA_SIZE];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock row FIFO with flush; accepts a push while full if the head is popped in the same cycle.
module sync_fifo #(
  parameter int width = 72,
  parameter int depth = 4
) (
  input  logic             s_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_cnt = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [aw:0]      count_reg;
  logic             push_en, pop_en;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == depth_cnt);
  assign pop_en  = pop && !empty && !clear;
  assign push_en = push && !clear && (!full || pop_en);

  // Head is presented straight from storage; masked to zero when nothing is buffered.
  assign rdata = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge s_clk) begin
    if (push_en) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + aw'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + aw'(1);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + (aw+1)'(1);
        2'b01:   count_reg <= count_reg - (aw+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mac_output_collector.sv
// Deskews the diagonal MAC wavefront into aligned rows, buffers them and counts drained rows per job.
// Optional COLLECT_RELU_EN clamps negative lanes to zero at the FIFO input.
module mac_output_collector
  import cnn_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int array_size = ARRAY_SIZE,
  parameter int fifo_depth = 4
) (
  input  logic                                s_clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [data_size*array_size-1:0]     macout,
  input  logic [7:0]                          rows_expected,
  output logic [data_size*array_size-1:0]     out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overflow,
  output logic                                done
);

  localparam int mac_size = data_size * array_size;
  localparam int vsr_len  = array_size - 1;

  wire  [mac_size-1:0] push_row;
  logic [vsr_len-1:0]  vsr_reg, vsr_next;
  logic                overflow_reg, overflow_next;
  logic [7:0]          job_cnt_reg, job_cnt_next, job_cnt_inc;
  logic                push_req, push, pop, drop, full, empty;

  genvar gi;
  generate
    for (gi = 0; gi < array_size; gi++) begin : g_lane
      localparam int depth = array_size - 1 - gi;
      logic [data_size-1:0] lane_in, lane_out;

      assign lane_in = macout[data_size*gi +: data_size];

      if (depth == 0) begin : g_pass
        assign lane_out = lane_in;
      end else begin : g_dly
        logic [data_size-1:0] dly_reg [depth];

        always_ff @(posedge s_clk or negedge reset) begin
          if (!reset || clear) begin
            if (!reset) for (int k = 0; k < depth; k++) dly_reg[k] <= '0;
            else        for (int k = 0; k < depth; k++) dly_reg[k] <= '0;
          end else begin
            dly_reg[0] <= lane_in;
            for (int k = 1; k < depth; k++) dly_reg[k] <= dly_reg[k-1];
          end
        end

        assign lane_out = dly_reg[depth-1];
      end

`ifdef COLLECT_RELU_EN
      assign push_row[data_size*gi +: data_size] = lane_out[data_size-1] ? '0 : lane_out;
`else
      assign push_row[data_size*gi +: data_size] = lane_out;
`endif
    end
  endgenerate

  // The last valid stage lines up with lane 0 leaving its delay line.
  assign push_req  = vsr_reg[vsr_len-1];
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !clear;
  assign push      = push_req && !clear && (!full || pop);
  assign drop      = push_req && !clear && full && !pop;
  assign overflow  = overflow_reg;

  always_comb begin
    vsr_next      = vsr_reg << 1;
    vsr_next[0]   = in_valid;
    overflow_next = overflow_reg | drop;
    job_cnt_inc   = job_cnt_reg + 8'd1;
    job_cnt_next  = job_cnt_reg;
    done          = 1'b0;
    if (pop) begin
      // A zero target never matches, so the counter simply wraps.
      if (rows_expected != 8'd0 && job_cnt_inc == rows_expected) begin
        done         = 1'b1;
        job_cnt_next = 8'd0;
      end else begin
        job_cnt_next = job_cnt_inc;
      end
    end
    if (clear) begin
      vsr_next      = '0;
      overflow_next = 1'b0;
      job_cnt_next  = 8'd0;
    end
  end

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      vsr_reg      <= '0;
      overflow_reg <= 1'b0;
      job_cnt_reg  <= 8'd0;
    end else begin
      vsr_reg      <= vsr_next;
      overflow_reg <= overflow_next;
      job_cnt_reg  <= job_cnt_next;
    end
  end

  sync_fifo #(
    .width (mac_size),
    .depth (fifo_depth)
  ) u_fifo (
    .s_clk (s_clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (push_row),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_mac_output_collector.sv
// Directed bench for mac_output_collector: skewed row driver, expected-row queue and per-pop done model.
module tb_mac_output_collector;
  import cnn_pkg::*;

  localparam int DS = DATA_SIZE;
  localparam int AS = ARRAY_SIZE;
  localparam int MS = MAC_SIZE;

  logic          s_clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    rows_expected = 8'd0;
  logic [MS-1:0] cur_row = '0;
  logic [MS-1:0] macout, out_data;
  logic          out_valid, overflow, done;
  logic [MS-1:0] hist [1:AS-1];

  logic [MS-1:0] exp_q [$];
  int            total = 0, passed = 0;
  int            pops = 0, done_seen = 0, job_pop = 0;
  logic [15:0]   done_mask = '0;
  logic [7:0]    tb_cnt = '0;

  mac_output_collector dut (
    .s_clk         (s_clk),
    .reset         (reset),
    .clear         (clear),
    .in_valid      (in_valid),
    .macout        (macout),
    .rows_expected (rows_expected),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 s_clk = ~s_clk;

  // Model of the array output: lane j of the row launched j cycles ago.
  always @(posedge s_clk) begin
    hist[1] <= cur_row;
    for (int k = 2; k < AS; k++) hist[k] <= hist[k-1];
  end

  always_comb begin
    macout = '0;
    for (int j = 0; j < AS; j++)
      macout[DS*j +: DS] = (j == 0) ? cur_row[DS*j +: DS] : hist[j][DS*j +: DS];
  end

  task automatic check(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [MS-1:0] seq_row(input int base);
    logic [MS-1:0] r;
    r = '0;
    for (int j = 0; j < AS; j++) r[DS*j +: DS] = DS'(base + j);
    return r;
  endfunction

  function automatic logic [MS-1:0] exp_row(input logic [MS-1:0] raw);
    logic [MS-1:0] r;
    r = raw;
`ifdef COLLECT_RELU_EN
    for (int j = 0; j < AS; j++) begin
      lane_t ln;
      ln = lane_slice(raw, j);
      if (ln[DS-1]) r[DS*j +: DS] = '0;
    end
`endif
    return r;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks done every cycle.
  always @(negedge s_clk) begin
    if (reset) begin
      logic pop_now, exp_done;
      logic [MS-1:0] expv;
      pop_now  = out_valid && out_ready && !clear;
      exp_done = pop_now && (rows_expected != 8'd0) && ((tb_cnt + 8'd1) == rows_expected);
      check("done", done, exp_done);
      if (pop_now) begin
        check("row_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          check("out_data", out_data, expv);
          $display("pop %0d data=%h done=%b", pops, out_data, done);
        end
        pops++;
        if (done) begin
          done_seen++;
          if (job_pop < 16) done_mask[job_pop] = 1'b1;
        end
        job_pop++;
        tb_cnt = exp_done ? 8'd0 : tb_cnt + 8'd1;
      end
      if (clear) tb_cnt = 8'd0;
    end else begin
      tb_cnt = 8'd0;
    end
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic send_row(input logic [MS-1:0] row, input bit accept);
    tick();
    in_valid = 1'b1;
    cur_row  = row;
    if (accept) exp_q.push_back(exp_row(row));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
      cur_row  = '0;
    end
  endtask

  task automatic do_clear();
    tick();
    clear    = 1'b1;
    in_valid = 1'b0;
    cur_row  = '0;
    exp_q.delete();
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int lat, pops0;
    logic [MS-1:0] relu_raw;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // Single row latency and content
    send_row(seq_row(1), 1'b1);
    idle(1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, 9);
    check("single_data", out_data, 72'h090807060504030201);
    check("single_overflow", overflow, 1'b0);
    idle(3);

    // Back-to-back rows, no bubbles
    pops0 = pops;
    for (int r = 0; r < 4; r++) send_row(seq_row(16 * r), 1'b1);
    idle(1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    for (int k = 0; k < 4; k++) begin
      check("b2b_valid", out_valid, 1'b1);
      tick();
    end
    check("b2b_end", out_valid, 1'b0);
    idle(2);
    check("b2b_pops", pops - pops0, 4);

    // Backpressure: fifth row dropped
    out_ready = 1'b0;
    pops0 = pops;
    for (int r = 0; r < 5; r++) send_row(seq_row(8'h30 + 16 * r), r < 4);
    idle(14);
    check("bp_overflow", overflow, 1'b1);
    check("bp_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    idle(8);
    check("bp_pops", pops - pops0, 4);
    check("bp_queue", exp_q.size(), 0);
    check("bp_empty", out_valid, 1'b0);

    // Clear with rows buffered and in flight
    out_ready = 1'b0;
    send_row(seq_row(8'h01), 1'b1);
    send_row(seq_row(8'h11), 1'b1);
    idle(12);
    send_row(seq_row(8'h21), 1'b1);
    send_row(seq_row(8'h31), 1'b1);
    idle(3);
    do_clear();
    check("clr_valid", out_valid, 1'b0);
    check("clr_overflow", overflow, 1'b0);
    check("clr_data", out_data, '0);
    out_ready = 1'b1;
    pops0 = pops;
    idle(16);
    check("clr_stale", pops - pops0, 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    pops0 = pops;
    for (int r = 0; r < 5; r++) send_row(seq_row(8'h40 + 8 * r), 1'b1);
    idle(7);
    tick();
    out_ready = 1'b1;
    check("fullpp_ovf_now", overflow, 1'b0);
    idle(10);
    check("fullpp_overflow", overflow, 1'b0);
    check("fullpp_pops", pops - pops0, 5);
    check("fullpp_queue", exp_q.size(), 0);

    // Job completion with rows_expected = 3
    do_clear();
    rows_expected = 8'd3;
    done_seen = 0;
    job_pop = 0;
    done_mask = '0;
    pops0 = pops;
    for (int r = 0; r < 7; r++) send_row(seq_row(8 * r), 1'b1);
    idle(16);
    check("job3_done_count", done_seen, 2);
    check("job3_done_mask", done_mask, 16'h0024);
    check("job3_pops", pops - pops0, 7);

    // rows_expected = 0 never completes
    rows_expected = 8'd0;
    do_clear();
    done_seen = 0;
    for (int r = 0; r < 5; r++) send_row(seq_row(8 * r + 2), 1'b1);
    idle(16);
    check("job0_done_count", done_seen, 0);

    // Signed lane pattern (clamped only with COLLECT_RELU_EN)
    relu_raw = 72'hC07E8140_01007FFF80;
    send_row(relu_raw, 1'b1);
    idle(14);
    check("relu_queue", exp_q.size(), 0);

    // Asynchronous reset mid-row
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) send_row(seq_row(8'h50 + 4 * r), r < 4);
    idle(14);
    check("arst_pre_overflow", overflow, 1'b1);
    send_row(seq_row(8'h60), 1'b0);
    idle(3);
    @(negedge s_clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, '0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_done", done, 1'b0);
    exp_q.delete();
    idle(3);
    reset = 1'b1;
    out_ready = 1'b1;
    pops0 = pops;
    idle(16);
    check("arst_stale", pops - pops0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_output_collector.md
# mac_output_collector

Output-side collector for the systolic MAC array. The input side feeds the array's rows through a staircase of row enables, so each result row leaves the array as a diagonal wavefront on `macout`. This block is the reading end of that wavefront. It deskews the per-column lanes back into aligned rows, buffers them in a small FIFO, and hands them downstream over a valid/ready handshake. It raises `done` once a programmed number of rows has been drained.

## Interface
Parameters:
- `data_size`, default 8: width of one MAC lane in bits.
- `array_size`, default 9: number of columns, which is also the number of lanes.
- `fifo_depth`, default 4: row FIFO depth; must be a power of 2 and at least 2.
- `mac_size`, localparam equal to `data_size*array_size`.

Ports:
- `s_clk`, in, 1: the only clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous flush, active-high.
- `in_valid`, in, 1: lane 0 of a new result row is present on `macout` this cycle.
- `macout`, in, `mac_size`: array outputs. Lane j is bits `[data_size*j +: data_size]`.
- `rows_expected`, in, 8: number of rows per job that must be drained before `done`.
- `out_data`, out, `mac_size`: aligned row at the FIFO head.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the row.
- `overflow`, out, 1: sticky flag; a row was dropped.
- `done`, out, 1: single-cycle pulse when a job completes.

## Operation
- **Skew model.** If `in_valid` is high at cycle t, lane j of that row is valid on `macout` at cycle t+j. Rows may arrive back-to-back, one per cycle.
- **Deskew.**
  - Lane j passes through a delay line of `array_size-1-j` registers. Lane `array_size-1` is not delayed.
  - `in_valid` passes through an `array_size-1`-stage shift register.
  - When the last stage is high, all lanes are aligned and the row is pushed to the FIFO.
- **FIFO push.**
  - Push happens when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the row is dropped and `overflow` is set.
- **FIFO pop.** A pop occurs when `out_valid && out_ready`. `out_data` is the FIFO head, read directly from the FIFO with no extra register.
- **Job counter.**
  - An 8-bit counter increments on each pop.
  - When a pop makes the count equal to `rows_expected`, `done` pulses for that cycle and the counter returns to 0.
  - If `rows_expected == 0`, `done` never fires and the counter wraps at 256.
  - `rows_expected` is sampled every cycle. Changing it mid-job is allowed; the comparison uses the current value.
- **`clear`.**
  - Zeroes the delay lines, the valid shift register, the FIFO pointers and count, the job counter and `overflow`.
  - `in_valid` and any pop in the same cycle are ignored.
  - `done` is 0 in a clear cycle.
- **Reset.** Asserting `reset` mid-row discards every in-flight row and buffered row immediately.
- **Arithmetic.** Lanes are passed bit-exact. No width change occurs except under the macro described in Configuration.

## Timing
- **Reset values:**
  - `out_data`: all zeros.
  - `out_valid`: 0.
  - `overflow`: 0.
  - `done`: 0.
  - Internal state: all zeros.
- **Latency.** With `in_valid` high at cycle t and the FIFO empty, `out_valid` rises at cycle t+`array_size` (t+9 by default). `out_data` equals {lane8@t+8, …, lane0@t}.
- **Throughput.** One row per cycle is sustained while `out_ready` is held high.
- **`done`.** Combinational on the pop cycle, i.e. high in the same cycle as the accepting handshake.
- **`overflow`.** Rises the cycle after the dropped push and holds until `clear` or `reset`.

## Configuration
- **With `COLLECT_RELU_EN` defined:** each lane is treated as a signed `data_size`-bit value at FIFO input. Negative lanes are forced to 0; non-negative lanes pass unchanged. Latency is unchanged.
- **Without it:** raw lane values are stored.

## Structure
- **Shared package `cnn_pkg`:** `DATA_SIZE`, `ARRAY_SIZE` and `MAC_SIZE` constants, plus a lane-slice function that returns lane j of a packed row.
- **Submodule `sync_fifo`:** width = `mac_size`, depth = `fifo_depth`. Uses the same clock, reset and clear. Exposes `full` and `empty`, and supports simultaneous push/pop when full.
- Deskew logic and job counter live in the top module.

## Test plan
- **Single row.**
  - Stimulus: `in_valid` at t; `macout` lane j at t+j = j+1; `out_ready` = 1.
  - Required: `out_valid` at t+9; `out_data` = 0x090807060504030201; `overflow` = 0.
- **Back-to-back rows.**
  - Stimulus: 4 consecutive rows, row r lane j = 16r+j; `out_ready` = 1.
  - Required: 4 consecutive valid outputs in order, each with correct lanes and no bubbles.
- **Backpressure/full.**
  - Stimulus: `out_ready` = 0; 5 rows sent.
  - Required: first 4 buffered, 5th dropped, `overflow` = 1. Then `out_ready` = 1 drains exactly 4 rows.
  - Required: full with simultaneous push and pop accepts the push, and `overflow` stays 0.
- **Job completion.**
  - Stimulus: `rows_expected` = 3; 7 rows sent.
  - Required: `done` pulses on the 3rd and 6th pops only.
  - Required: with `rows_expected` = 0, `done` never pulses.
- **Clear/reset mid-flight.**
  - Stimulus: `clear` while 2 rows are in the delay lines and 2 are in the FIFO.
  - Required: `out_valid` = 0 next cycle, `overflow` = 0, and no stale rows emerge later.
  - Required: `reset` asserted asynchronously mid-row forces all outputs to 0 at once.
- **`COLLECT_RELU_EN`.**
  - Stimulus: lanes = 0x80, 0xFF, 0x7F, 0x00, …
  - Required: with the macro, outputs are 0, 0, 0x7F, 0; without it, values pass unchanged.
